// File: rtl/cnn_layer_sequencer_if.sv
// Control/status bundle between the CNN layer sequencer and its layer pipeline.
// master: the sequencer; slave: whoever issues runs and answers with done lines.
interface cnn_layer_sequencer_if #(
    parameter int SAMPLE_W = 16
);
    logic                start;
    logic                abort;
    logic [SAMPLE_W-1:0] num_samples;
    logic                conv_done;
    logic                pool_done;
    logic                fc_done;
    logic                conv_enable;
    logic                pool_enable;
    logic                fc_enable;
    logic [SAMPLE_W-1:0] sample_idx;
    logic                sample_done;
    logic                batch_done;
    logic                busy;
    logic                seq_done;
    logic                timeout_err;
    logic [1:0]          err_layer;

    modport master (
        input  start, abort, num_samples,
        input  conv_done, pool_done, fc_done,
        output conv_enable, pool_enable, fc_enable,
        output sample_idx, sample_done, batch_done,
        output busy, seq_done, timeout_err, err_layer
    );

    modport slave (
        output start, abort, num_samples,
        output conv_done, pool_done, fc_done,
        input  conv_enable, pool_enable, fc_enable,
        input  sample_idx, sample_done, batch_done,
        input  busy, seq_done, timeout_err, err_layer
    );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// Drives conv -> pool -> fc per sample, counts samples/batches and
// guards every stage with a watchdog that parks the block in ERR on a stall.
module cnn_layer_sequencer #(
    parameter int SAMPLE_W       = 16,
    parameter int BATCH_SIZE     = 32,
    parameter int TIMEOUT_W      = 20,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic                  clk,
    input logic                  reset,
    cnn_layer_sequencer_if.master bus
);
    localparam int BW = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
    localparam logic [BW-1:0] BATCH_LAST = BW'(BATCH_SIZE - 1);
    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, CONV, POOL, FC, NEXT, ERR} state_t;

    state_t              state_q, state_d;
    logic [SAMPLE_W-1:0] num_q, num_d;
    logic [SAMPLE_W-1:0] idx_q, idx_d;
    logic [BW-1:0]       batch_q, batch_d;
    logic [TIMEOUT_W-1:0] wdog_q;
    logic                conv_q, pool_q, fc_q;
    logic                sample_done_q, sample_done_d;
    logic                batch_done_q, batch_done_d;
    logic                seq_done_q, seq_done_d;
    logic                err_q, err_d;
    logic [1:0]          layer_q, layer_d;

    logic conv_edge, pool_edge, fc_edge;
    logic is_last, wd_hit, batch_end, in_stage;

    assign conv_edge = bus.conv_done & ~conv_q;
    assign pool_edge = bus.pool_done & ~pool_q;
    assign fc_edge   = bus.fc_done & ~fc_q;
    assign is_last   = (idx_q == num_q - SAMPLE_W'(1));
    assign wd_hit    = (wdog_q == WD_LAST);
    assign batch_end = (batch_q == BATCH_LAST);
    assign in_stage  = (state_q == CONV) || (state_q == POOL) || (state_q == FC);

    always_comb begin
        state_d       = state_q;
        num_d         = num_q;
        idx_d         = idx_q;
        batch_d       = batch_q;
        sample_done_d = 1'b0;
        batch_done_d  = 1'b0;
        seq_done_d    = 1'b0;
        err_d         = err_q;
        layer_d       = layer_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, ERR: begin
                    if (bus.start) begin
                        num_d   = bus.num_samples;
                        idx_d   = '0;
                        batch_d = '0;
                        err_d   = 1'b0;
                        layer_d = 2'd0;
                        if (bus.num_samples == '0) begin
                            seq_done_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d = CONV;
                        end
                    end
                end
                CONV: begin
                    if (conv_edge) begin
                        state_d = POOL;
                    end else if (wd_hit) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        layer_d = 2'd1;
                    end
                end
                POOL: begin
                    if (pool_edge) begin
                        state_d = FC;
                    end else if (wd_hit) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        layer_d = 2'd2;
                    end
                end
                FC: begin
                    if (fc_edge) begin
                        sample_done_d = 1'b1;
                        batch_done_d  = batch_end | is_last;
                        batch_d       = batch_end ? '0 : batch_q + 1'b1;
                        if (is_last) begin
                            seq_done_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d = NEXT;
                        end
                    end else if (wd_hit) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        layer_d = 2'd3;
                    end
                end
                NEXT: begin
                    idx_d   = idx_q + 1'b1;
                    state_d = CONV;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            num_q         <= '0;
            idx_q         <= '0;
            batch_q       <= '0;
            wdog_q        <= '0;
            conv_q        <= 1'b0;
            pool_q        <= 1'b0;
            fc_q          <= 1'b0;
            sample_done_q <= 1'b0;
            batch_done_q  <= 1'b0;
            seq_done_q    <= 1'b0;
            err_q         <= 1'b0;
            layer_q       <= 2'd0;
        end else begin
            state_q       <= state_d;
            num_q         <= num_d;
            idx_q         <= idx_d;
            batch_q       <= batch_d;
            conv_q        <= bus.conv_done;
            pool_q        <= bus.pool_done;
            fc_q          <= bus.fc_done;
            sample_done_q <= sample_done_d;
            batch_done_q  <= batch_done_d;
            seq_done_q    <= seq_done_d;
            err_q         <= err_d;
            layer_q       <= layer_d;
            // Any state change restarts the watchdog for the stage being entered.
            if (state_d != state_q) begin
                wdog_q <= '0;
            end else if (in_stage) begin
                wdog_q <= wdog_q + 1'b1;
            end
        end
    end

    assign bus.conv_enable = (state_q == CONV);
    assign bus.pool_enable = (state_q == POOL);
    assign bus.fc_enable   = (state_q == FC);
    assign bus.busy        = in_stage || (state_q == NEXT);
    assign bus.sample_idx  = idx_q;
    assign bus.sample_done = sample_done_q;
    assign bus.batch_done  = batch_done_q;
    assign bus.seq_done    = seq_done_q;
    assign bus.timeout_err = err_q;
    assign bus.err_layer   = layer_q;
endmodule
